// File: rtl/riscv_core_pkg.sv
// Shared definitions for the core's M-extension multiply path.
package riscv_core_pkg;

  localparam logic [1:0] MUL_CTRL_MUL    = 2'b00;
  localparam logic [1:0] MUL_CTRL_MULH   = 2'b01;
  localparam logic [1:0] MUL_CTRL_MULHSU = 2'b10;
  localparam logic [1:0] MUL_CTRL_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_MULW
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_ctrl_state_e;

  // isword overrides control: MULW only exists with control 00.
  function automatic mul_op_e decode_mul_op(input logic [1:0] control, input logic isword);
    mul_op_e op;
    if (isword) begin
      op = OP_MULW;
    end else begin
      case (control)
        MUL_CTRL_MUL:    op = OP_MUL;
        MUL_CTRL_MULH:   op = OP_MULH;
        MUL_CTRL_MULHSU: op = OP_MULHSU;
        default:         op = OP_MULHU;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/riscv_core_mul_in.sv
// Operand conditioning: turns rs1/rs2 into unsigned magnitudes plus the sign of the
// final product, according to the signedness of the requested multiply.
module riscv_core_mul_in
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [1:0]      control,
  input  logic            isword,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            neg
);

  localparam int HALF = XLEN / 2;

  mul_op_e         op;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic [HALF-1:0] a_mag_word;
  logic [HALF-1:0] b_mag_word;
  logic [XLEN-1:0] a_mag_full;
  logic [XLEN-1:0] b_mag_full;

  always_comb begin
    op       = decode_mul_op(control, isword);
    a_signed = (op != OP_MULHU);
    b_signed = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULW);

    a_neg = a_signed && (isword ? src_a[HALF-1] : src_a[XLEN-1]);
    b_neg = b_signed && (isword ? src_b[HALF-1] : src_b[XLEN-1]);

    // Negating the most-negative value yields itself, which is the right unsigned magnitude.
    a_mag_full = a_neg ? -src_a : src_a;
    b_mag_full = b_neg ? -src_b : src_b;
    a_mag_word = a_neg ? -src_a[HALF-1:0] : src_a[HALF-1:0];
    b_mag_word = b_neg ? -src_b[HALF-1:0] : src_b[HALF-1:0];

    mag_a = isword ? {{HALF{1'b0}}, a_mag_word} : a_mag_full;
    mag_b = isword ? {{HALF{1'b0}}, b_mag_word} : b_mag_full;
    neg   = a_neg ^ b_neg;
  end

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// Iterative radix-2 shift-add multiplier sequencer for MUL/MULH/MULHSU/MULHU/MULW.
// Stalls execute (ready low, busy high) from accept until the result is acknowledged.
module riscv_core_mul_ctrl
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_mul_ctrl_clk,
  input  logic            i_mul_ctrl_rstn,
  input  logic            i_mul_ctrl_valid,
  output logic            o_mul_ctrl_ready,
  input  logic [XLEN-1:0] i_mul_ctrl_srcA,
  input  logic [XLEN-1:0] i_mul_ctrl_srcB,
  input  logic [1:0]      i_mul_ctrl_control,
  input  logic            i_mul_ctrl_isword,
  input  logic            i_mul_ctrl_flush,
  output logic            o_mul_ctrl_valid,
  input  logic            i_mul_ctrl_ack,
  output logic [XLEN-1:0] o_mul_ctrl_result,
  output logic            o_mul_ctrl_busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] ITER_FULL = CW'(XLEN);
  localparam logic [CW-1:0] ITER_WORD = CW'(HALF);

  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            neg_in;

  riscv_core_mul_in #(.XLEN(XLEN)) u_mul_in (
    .src_a   (i_mul_ctrl_srcA),
    .src_b   (i_mul_ctrl_srcB),
    .control (i_mul_ctrl_control),
    .isword  (i_mul_ctrl_isword),
    .mag_a   (mag_a),
    .mag_b   (mag_b),
    .neg     (neg_in)
  );

  mul_ctrl_state_e   state;
  mul_op_e           op;
  logic              neg;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;
  logic [CW-1:0]     count;
  logic [CW-1:0]     iter;
  logic              ready;
  logic              valid;
  logic              busy;
  logic [XLEN-1:0]   result;

  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   result_sel;

  always_comb begin
    sum      = {1'b0, prod[2*XLEN-1:XLEN]} + ({1'b0, mcand} & {(XLEN+1){prod[0]}});
    prod_fix = neg ? (~prod + (2*XLEN)'(1)) : prod;
    result_sel = prod_fix[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:  result_sel = prod_fix[XLEN-1:0];
      // Word product low half lands at P[XLEN-1:HALF] after HALF iterations.
      OP_MULW: result_sel = {{HALF{prod_fix[XLEN-1]}}, prod_fix[XLEN-1:HALF]};
      default: result_sel = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge i_mul_ctrl_clk) begin
    if (!i_mul_ctrl_rstn) begin
      state  <= IDLE;
      op     <= OP_MUL;
      neg    <= 1'b0;
      mcand  <= '0;
      prod   <= '0;
      count  <= '0;
      iter   <= '0;
      ready  <= 1'b1;
      valid  <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
    end else if (i_mul_ctrl_flush) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_mul_ctrl_valid) begin
            op    <= decode_mul_op(i_mul_ctrl_control, i_mul_ctrl_isword);
            neg   <= neg_in;
            mcand <= mag_a;
            prod  <= {{XLEN{1'b0}}, mag_b};
            count <= '0;
            iter  <= i_mul_ctrl_isword ? ITER_WORD : ITER_FULL;
            ready <= 1'b0;
            busy  <= 1'b1;
            if (mag_a == '0 || mag_b == '0) begin
              result <= '0;
              valid  <= 1'b1;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod  <= {sum, prod[XLEN-1:1]};
          count <= count + CW'(1);
          if (count == iter - CW'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          result <= result_sel;
          valid  <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          if (i_mul_ctrl_ack) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_mul_ctrl_ready  = ready;
  assign o_mul_ctrl_valid  = valid;
  assign o_mul_ctrl_busy   = busy;
  assign o_mul_ctrl_result = result;

endmodule
